reg_scoreboard: RTL
===================

# reg_scoreboard

Parametrised register-dependency scoreboard for the ID stage, the sequential successor to the combinational read/write-address decoder. It receives the decoded read addresses, write address and write latency of the instruction in ID and tracks every in-flight register write. It decides each cycle whether that instruction may issue. RAW and WAW hazards, including multi-cycle producers such as loads, mult/div and MFC0, stall in ID instead of relying on ad-hoc pipeline checks.

## Interface
- REG_NUM, 32, architectural register count; register 0 is hardwired zero
- REG_ADDR_W, 5, register address width, equal to clog2(REG_NUM)
- READ_PORTS, 2, source operands checked per instruction
- WB_PORTS, 2, writeback ports able to retire a pending write per cycle
- CNT_W, 3, width of the per-register latency counter
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush (exception/eret); clears all pending state
- id_valid  in  1  ID holds a valid instruction
- id_read_en  in  READ_PORTS  per-port source enable
- id_read_addr  in  READ_PORTS*REG_ADDR_W  packed source addresses, port 0 in LSBs
- id_write_en  in  1  instruction writes a register
- id_write_addr  in  REG_ADDR_W  destination address
- id_write_lat  in  CNT_W  cycles after issue until result is forwardable; 0 = unknown, wait for writeback
- ex_ready  in  1  EX accepts an instruction this cycle
- id_ready  out  1  no hazard; instruction may issue
- id_fire  out  1  id_valid & id_ready & ex_ready; the issue event
- stall_raw  out  1  RAW hazard present (diagnostic)
- stall_waw  out  1  WAW hazard present (diagnostic)
- busy_vec  out  REG_NUM  registered per-register busy bits

## Operation
- Per-register state: busy (1 b) and cnt (CNT_W b); register 0 is never busy, and writes or reads of r0 are ignored.
- Source i is hazardous when id_read_en[i] is set, its address is non-zero, busy[addr] is set, the address is not forward-ready, and no wb_en[j] with wb_addr[j]==addr is asserted this cycle. This is the same-cycle writeback bypass.
- stall_raw = OR over sources of hazardous, gated by id_valid.
- stall_waw = id_valid & id_write_en & addr!=0 & busy[id_write_addr] & not cleared by a same-cycle writeback. In-order completion is preserved.
- id_ready = !stall_raw & !stall_waw & !rst & !flush.
- On id_fire with id_write_en & addr!=0: the next state of that register is busy=1, cnt=id_write_lat.
- On wb_en[j]: the next state of register wb_addr[j] is busy=0, cnt=0.
- Simultaneous issue-set and writeback-clear of the same register: set wins.
- Each cycle, every busy register with cnt>1 decrements cnt. cnt saturates at 1 until cleared by writeback.
- flush: the next state of all registers is busy=0, cnt=0; any issue in the flush cycle is suppressed.

## Timing
- Reset (rst high at edge): busy_vec=0, all cnt=0. id_ready, id_fire, stall_raw and stall_waw are 0 while rst is high. id_ready=1 in the first cycle after release when no hazard exists.
- id_ready, id_fire, stall_raw and stall_waw are combinational from registered state plus current inputs. There is no latency from writeback to ready: same-cycle bypass.
- busy_vec is updated one cycle after id_fire or wb_en.
- Latency L≥1 producer issued at cycle t: a dependent instruction may issue at cycle t+L (with SCOREBOARD_FWD_EN) or in the writeback cycle (without it).
- Reset or flush mid-operation discards all pending state. Writebacks arriving after the flush clear nothing further and are harmless.

## Configuration
- SCOREBOARD_FWD_EN defined: a register is forward-ready when busy & cnt==1; dependents issue on the forwarding path.
- Not defined: cnt is neither stored nor decremented (synthesised away). A register is ready only on writeback clear or same-cycle writeback bypass. id_write_lat is ignored.

## Structure
- Shared header (alongside bus.v): REG_NUM, REG_ADDR_W, and the latency codes LAT_ALU=1, LAT_LOAD=2, LAT_MDU=0 (wait for writeback) used by ID to drive id_write_lat.
- One sub-module, scoreboard_entry: busy/cnt flop pair, set/clear/decrement logic and the forward_ready output, instantiated REG_NUM-1 times via generate. The top level holds the address compare, hazard reduction and handshake.

## Test plan
- Reset release: busy_vec=0; id_valid with read r5 -> id_ready=1 and id_fire=1 with ex_ready=1.
- Issue write r3 lat=1 at t; at t+1 read r3 -> ready=1 with SCOREBOARD_FWD_EN, stall_raw=1 without. wb r3 at t+3 -> ready=1 that cycle, busy[3]=0 at t+4.
- Load r8 lat=2, then issue read r8: stall at t+1 (FWD_EN); ready at t+2.
- Issue write r4 lat=0, then a second write r4 -> stall_waw=1 until wb_en[1] r4; ready in the wb cycle.
- Same-cycle id_fire writing r7 and wb r7 -> busy[7]=1 next cycle (set wins). Read of r0 or write to r0 never stalls.
- Two pending writes r2/r9, then flush=1 -> id_ready=0 that cycle, busy_vec=0 next; rst mid-stall gives the same result.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared scoreboard constants: register file geometry and the write-latency
// codes ID drives onto id_write_lat.
package reg_scoreboard_pkg;

  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = $clog2(REG_NUM);
  localparam int CNT_W      = 3;

  // Cycles from issue until the result is forwardable; 0 means the result
  // is only usable once the writeback port retires it.
  localparam logic [CNT_W-1:0] LAT_ALU  = 3'd1;
  localparam logic [CNT_W-1:0] LAT_LOAD = 3'd2;
  localparam logic [CNT_W-1:0] LAT_MDU  = 3'd0;

endpackage

// File: rtl/reg_scoreboard_entry.sv
// One scoreboard slot: busy flag plus, when SCOREBOARD_FWD_EN is defined,
// a countdown to the cycle the pending result becomes forwardable.
// Issue-set beats writeback-clear; flush beats both.
module reg_scoreboard_entry #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             set_i,
  input  logic [CNT_W-1:0] lat_i,
  input  logic             clr_i,
  output logic             busy_o,
  output logic             fwd_ready_o
);

  logic busy_q, busy_d;

  // Busy next-state: clear on writeback, set on issue, flush discards all.
  always_comb begin
    // NOTE: combinational blocks assign every output a default first and use
    // blocking '=' so later lines override earlier ones and no latch appears.
    busy_d = busy_q;
    if (clr_i)   busy_d = 1'b0;
    if (set_i)   busy_d = 1'b1;
    if (flush_i) busy_d = 1'b0;
  end

  // Busy flag register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // values from before the edge.
    if (rst) busy_q <= 1'b0;
    else     busy_q <= busy_d;
  end

  assign busy_o = busy_q;

`ifdef SCOREBOARD_FWD_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Countdown: decrement toward 1 and hold there until writeback clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (busy_q && cnt_q > CNT_W'(1)) cnt_d = cnt_q - CNT_W'(1);
    if (clr_i)   cnt_d = '0;
    if (set_i)   cnt_d = lat_i;
    if (flush_i) cnt_d = '0;
  end

  // Latency counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign fwd_ready_o = busy_q && (cnt_q == CNT_W'(1));
`else
  // Without forwarding the latency is irrelevant; only writeback frees a slot.
  logic unused_lat;
  assign unused_lat  = ^lat_i;
  assign fwd_ready_o = 1'b0;
`endif

endmodule

// File: rtl/reg_scoreboard.sv
// Register-dependency scoreboard for the ID stage. Tracks in-flight writes and
// stalls the instruction in ID on RAW/WAW hazards, with same-cycle writeback
// bypass. Optional macro SCOREBOARD_FWD_EN lets dependents issue once a
// producer's latency has elapsed instead of waiting for writeback.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int REG_NUM    = reg_scoreboard_pkg::REG_NUM,
  parameter int REG_ADDR_W = reg_scoreboard_pkg::REG_ADDR_W,
  parameter int READ_PORTS = 2,
  parameter int WB_PORTS   = 2,
  parameter int CNT_W      = reg_scoreboard_pkg::CNT_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             id_valid,
  input  logic [READ_PORTS-1:0]            id_read_en,
  input  logic [READ_PORTS*REG_ADDR_W-1:0] id_read_addr,
  input  logic                             id_write_en,
  input  logic [REG_ADDR_W-1:0]            id_write_addr,
  input  logic [CNT_W-1:0]                 id_write_lat,
  input  logic [WB_PORTS-1:0]              wb_en,
  input  logic [WB_PORTS*REG_ADDR_W-1:0]   wb_addr,
  input  logic                             ex_ready,
  output logic                             id_ready,
  output logic                             id_fire,
  output logic                             stall_raw,
  output logic                             stall_waw,
  output logic [REG_NUM-1:0]               busy_vec
);

  logic [REG_NUM-1:0]    wb_hit;
  logic [REG_NUM-1:0]    set_vec;
  logic [REG_NUM-1:0]    fwd_vec;
  logic                  raw_any;
  logic                  waw_any;
  logic [REG_ADDR_W-1:0] rd_addr;

  // Decode the writeback ports into a per-register clear mask.
  always_comb begin
    wb_hit = '0;
    for (int j = 0; j < WB_PORTS; j++) begin
      if (wb_en[j]) wb_hit[wb_addr[j*REG_ADDR_W +: REG_ADDR_W]] = 1'b1;
    end
  end

  // Decode the issuing instruction's destination into a per-register set mask.
  always_comb begin
    set_vec = '0;
    if (id_fire && id_write_en) set_vec[id_write_addr] = 1'b1;
  end

  // r0 is hardwired zero: never busy, never forwarded.
  assign busy_vec[0] = 1'b0;
  assign fwd_vec[0]  = 1'b0;

  logic unused_r0;
  assign unused_r0 = set_vec[0];

  for (genvar r = 1; r < REG_NUM; r++) begin : g_entry
    reg_scoreboard_entry #(.CNT_W(CNT_W)) u_entry (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush),
      .set_i      (set_vec[r]),
      .lat_i      (id_write_lat),
      .clr_i      (wb_hit[r]),
      .busy_o     (busy_vec[r]),
      .fwd_ready_o(fwd_vec[r])
    );
  end

  // RAW: an enabled non-zero source whose producer is neither forwardable
  // nor retiring this cycle.
  always_comb begin
    raw_any = 1'b0;
    rd_addr = '0;
    for (int i = 0; i < READ_PORTS; i++) begin
      rd_addr = id_read_addr[i*REG_ADDR_W +: REG_ADDR_W];
      if (id_read_en[i] && rd_addr != '0 && busy_vec[rd_addr] &&
          !fwd_vec[rd_addr] && !wb_hit[rd_addr])
        raw_any = 1'b1;
    end
  end

  // WAW: destination still pending and not retiring this cycle; keeps
  // writes to one register completing in order.
  assign waw_any = id_write_en && (id_write_addr != '0) &&
                   busy_vec[id_write_addr] && !wb_hit[id_write_addr];

  assign stall_raw = id_valid && raw_any && !rst;
  assign stall_waw = id_valid && waw_any && !rst;
  assign id_ready  = !stall_raw && !stall_waw && !rst && !flush;
  assign id_fire   = id_valid && id_ready && ex_ready;

endmodule
